// File: rtl/decode_stage_pipe_if.sv
// +----------------------------------------------------------------------------+
// | decode_stage_pipe_if                                                       |
// | Fetch, writeback and ID/EX signals for the decode stage.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface decode_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_address;
  logic            flush;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] opa_mux_out;
  logic [XLEN-1:0] opb_mux_out;
  logic [XLEN-1:0] opb_data;
  logic [3:0]      alu_control;
  logic [1:0]      mem_to_reg;
  logic            load;
  logic            store;
  logic            reg_write;
  logic [AW-1:0]   rd;
  logic            next_sel;
  logic            branch_result;

  modport master (
    output in_valid, instruction, pc_address, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, opa_mux_out, opb_mux_out, opb_data, alu_control,
           mem_to_reg, load, store, reg_write, rd, next_sel, branch_result
  );

  modport slave (
    input  in_valid, instruction, pc_address, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, opa_mux_out, opb_mux_out, opb_data, alu_control,
           mem_to_reg, load, store, reg_write, rd, next_sel, branch_result
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage_pipe.sv
// +----------------------------------------------------------------------------+
// | decode_stage_pipe                                                          |
// | RV32I decode with regfile, RAW scoreboard and registered ID/EX output.     |
// | Optional feature macro: DECODE_WB_BYPASS_EN (same-cycle writeback bypass). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input logic                clk,
  input logic                rst,
  decode_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_MAX_M1 = c_CNT_MAX - CNT_W'(1);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  localparam logic [3:0] c_ALU_ADD = 4'd0, c_ALU_SUB = 4'd1, c_ALU_SLL = 4'd2,
                         c_ALU_SLT = 4'd3, c_ALU_SLTU = 4'd4, c_ALU_XOR = 4'd5,
                         c_ALU_SRL = 4'd6, c_ALU_SRA = 4'd7, c_ALU_OR = 4'd8,
                         c_ALU_AND = 4'd9, c_ALU_PASSB = 4'd10;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  alu_sel = (is_reg && alt) ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  alu_sel = c_ALU_SLL;
      3'b010:  alu_sel = c_ALU_SLT;
      3'b011:  alu_sel = c_ALU_SLTU;
      3'b100:  alu_sel = c_ALU_XOR;
      3'b101:  alu_sel = alt ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  alu_sel = c_ALU_OR;
      default: alu_sel = c_ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CNT_W-1:0] r_cnt  [NREGS];

  logic            r_out_valid, r_load, r_store, r_reg_write, r_next_sel, r_branch;
  logic [XLEN-1:0] r_out_pc, r_opa, r_opb, r_opb_data;
  logic [3:0]      r_alu;
  logic [1:0]      r_m2r;
  logic [AW-1:0]   r_rd;

  logic [31:0]     w_ins;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [AW-1:0]   w_rs1, w_rs2, w_rd;
  assign w_ins    = bus.instruction;
  assign w_opcode = w_ins[6:0];
  assign w_funct3 = w_ins[14:12];
  assign w_rs1    = w_ins[15 +: AW];
  assign w_rs2    = w_ins[20 +: AW];
  assign w_rd     = w_ins[7 +: AW];

  logic              w_use_rs1, w_use_rs2, w_wr, w_ld, w_st, w_opa_pc, w_opb_imm, w_jmp, w_brn;
  logic [3:0]        w_alu;
  logic [1:0]        w_m2r;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm;

  always_comb begin
    w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_wr  = 1'b0; w_ld  = 1'b0; w_st = 1'b0;
    w_opa_pc  = 1'b0; w_opb_imm = 1'b0; w_jmp = 1'b0; w_brn = 1'b0;
    w_alu     = c_ALU_ADD; w_m2r = 2'd0;
    w_imm32   = {{20{w_ins[31]}}, w_ins[31:20]};
    case (w_opcode)
      c_OP_LUI:    begin w_wr = 1'b1; w_opb_imm = 1'b1; w_alu = c_ALU_PASSB;
                         w_imm32 = {w_ins[31:12], 12'b0}; end
      c_OP_AUIPC:  begin w_wr = 1'b1; w_opa_pc = 1'b1; w_opb_imm = 1'b1;
                         w_imm32 = {w_ins[31:12], 12'b0}; end
      c_OP_JAL:    begin w_wr = 1'b1; w_opa_pc = 1'b1; w_opb_imm = 1'b1; w_jmp = 1'b1; w_m2r = 2'd2;
                         w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}; end
      c_OP_JALR:   begin w_wr = 1'b1; w_use_rs1 = 1'b1; w_opb_imm = 1'b1; w_jmp = 1'b1; w_m2r = 2'd2; end
      c_OP_BRANCH: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_opa_pc = 1'b1; w_opb_imm = 1'b1; w_brn = 1'b1;
                         w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}; end
      c_OP_LOAD:   begin w_wr = 1'b1; w_use_rs1 = 1'b1; w_opb_imm = 1'b1; w_ld = 1'b1; w_m2r = 2'd1; end
      c_OP_STORE:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_opb_imm = 1'b1; w_st = 1'b1;
                         w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]}; end
      c_OP_IMM:    begin w_wr = 1'b1; w_use_rs1 = 1'b1; w_opb_imm = 1'b1;
                         w_alu = alu_sel(w_funct3, w_ins[30], 1'b0); end
      c_OP_REG:    begin w_wr = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                         w_alu = alu_sel(w_funct3, w_ins[30], 1'b1); end
      default: ;
    endcase
  end
  assign w_imm = XLEN'(w_imm32);

  logic            w_wb_rs1, w_wb_rs2, w_wb_rd, w_wb_stall;
  logic [XLEN-1:0] w_rf_rs1, w_rf_rs2, w_rs1_val, w_rs2_val;
  logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
  assign w_wb_rs1 = bus.wb_en && (bus.wb_rd == w_rs1) && (w_rs1 != '0);
  assign w_wb_rs2 = bus.wb_en && (bus.wb_rd == w_rs2) && (w_rs2 != '0);
  assign w_wb_rd  = bus.wb_en && (bus.wb_rd == w_rd)  && (w_rd  != '0);
  assign w_rf_rs1 = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_rf_rs2 = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

`ifdef DECODE_WB_BYPASS_EN
  // The pending decrement is applied to the lookup so the writeback cycle itself can issue
  assign w_cnt_rs1  = r_cnt[w_rs1] - CNT_W'(w_wb_rs1 && (r_cnt[w_rs1] != '0));
  assign w_cnt_rs2  = r_cnt[w_rs2] - CNT_W'(w_wb_rs2 && (r_cnt[w_rs2] != '0));
  assign w_cnt_rd   = r_cnt[w_rd]  - CNT_W'(w_wb_rd  && (r_cnt[w_rd]  != '0));
  assign w_wb_stall = 1'b0;
  assign w_rs1_val  = w_wb_rs1 ? bus.wb_data : w_rf_rs1;
  assign w_rs2_val  = w_wb_rs2 ? bus.wb_data : w_rf_rs2;
`else
  assign w_cnt_rs1  = r_cnt[w_rs1];
  assign w_cnt_rs2  = r_cnt[w_rs2];
  assign w_cnt_rd   = r_cnt[w_rd];
  assign w_wb_stall = (w_use_rs1 && w_wb_rs1) || (w_use_rs2 && w_wb_rs2);
  assign w_rs1_val  = w_rf_rs1;
  assign w_rs2_val  = w_rf_rs2;
`endif

  logic w_held_wr, w_raw1, w_raw2, w_sat, w_hazard, w_in_ready, w_accept, w_sb_inc;
  assign w_held_wr = r_out_valid && r_reg_write;
  assign w_raw1 = w_use_rs1 && (w_rs1 != '0) && ((w_cnt_rs1 != '0) || (w_held_wr && (r_rd == w_rs1)));
  assign w_raw2 = w_use_rs2 && (w_rs2 != '0) && ((w_cnt_rs2 != '0) || (w_held_wr && (r_rd == w_rs2)));
  // A held writer to the same rd will increment before this one can, so count it too
  assign w_sat  = w_wr && (w_rd != '0) &&
                  ((w_cnt_rd == c_CNT_MAX) || ((w_cnt_rd == c_CNT_MAX_M1) && w_held_wr && (r_rd == w_rd)));
  assign w_hazard   = w_raw1 || w_raw2 || w_sat || w_wb_stall;
  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sb_inc   = r_out_valid && bus.out_ready && !bus.flush && r_reg_write && (r_rd != '0);

  logic w_cond;
  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      3'b000: w_cond = (w_rs1_val == w_rs2_val);
      3'b001: w_cond = (w_rs1_val != w_rs2_val);
      3'b100: w_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101: w_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110: w_cond = (w_rs1_val <  w_rs2_val);
      3'b111: w_cond = (w_rs1_val >= w_rs2_val);
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.wb_en && (bus.wb_rd != '0)) r_regs[bus.wb_rd] <= bus.wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        logic v_inc, v_dec;
        v_inc = w_sb_inc && (r_rd == AW'(i));
        v_dec = bus.wb_en && (bus.wb_rd == AW'(i)) && (i != 0) && (r_cnt[i] != '0);
        if (v_inc && !v_dec)      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (v_dec && !v_inc) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0; r_out_pc <= '0; r_opa <= '0; r_opb <= '0; r_opb_data <= '0;
      r_alu <= '0; r_m2r <= '0; r_load <= 1'b0; r_store <= 1'b0; r_reg_write <= 1'b0;
      r_rd <= '0; r_next_sel <= 1'b0; r_branch <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= bus.pc_address;
      r_opa       <= w_opa_pc ? bus.pc_address : w_rs1_val;
      r_opb       <= w_opb_imm ? w_imm : w_rs2_val;
      r_opb_data  <= w_rs2_val;
      r_alu       <= w_alu;
      r_m2r       <= w_m2r;
      r_load      <= w_ld;
      r_store     <= w_st;
      r_reg_write <= w_wr;
      r_rd        <= w_rd;
      r_next_sel  <= w_jmp;
      r_branch    <= w_brn && w_cond;
    end else if (bus.flush || bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out_pc;
  assign bus.opa_mux_out   = r_opa;
  assign bus.opb_mux_out   = r_opb;
  assign bus.opb_data      = r_opb_data;
  assign bus.alu_control   = r_alu;
  assign bus.mem_to_reg    = r_m2r;
  assign bus.load          = r_load;
  assign bus.store         = r_store;
  assign bus.reg_write     = r_reg_write;
  assign bus.rd            = r_rd;
  assign bus.next_sel      = r_next_sel;
  assign bus.branch_result = r_branch;
endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_decode_stage_pipe                                                       |
// | Directed self-checking bench for decode_stage_pipe.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32), .AW(5)) dif ();
  decode_stage_pipe #(.XLEN(32), .NREGS(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(dif));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    dif.in_valid = 0; dif.instruction = 0; dif.pc_address = 0; dif.flush = 0;
    dif.wb_en = 0; dif.wb_rd = 0; dif.wb_data = 0; dif.out_ready = 0;
    tick(); tick();
    chk("rst_out_valid", 32'(dif.out_valid), 0);
    chk("rst_opb", dif.opb_mux_out, 0);
    chk("rst_cnt3", 32'(dut.r_cnt[3]), 0);
    rst = 0;

    // ADDI x1,x0,5 held with out_ready low
    dif.in_valid = 1; dif.instruction = 32'h00500093; dif.pc_address = 32'h100;
    #1 chk("t1_in_ready", 32'(dif.in_ready), 1);
    tick();
    dif.in_valid = 0;
    chk("t1_valid", 32'(dif.out_valid), 1);
    chk("t1_opb", dif.opb_mux_out, 5);
    chk("t1_opa", dif.opa_mux_out, 0);
    chk("t1_alu", 32'(dif.alu_control), 0);
    chk("t1_rd", 32'(dif.rd), 1);
    chk("t1_pc", dif.out_pc, 32'h100);
    tick();
    chk("hold_valid", 32'(dif.out_valid), 1);
    chk("hold_opb", dif.opb_mux_out, 5);

    // ADD x2,x1,x1 behind the ADDI x1
    dif.in_valid = 1; dif.instruction = 32'h00108133; dif.pc_address = 32'h104; dif.out_ready = 1;
    #1 chk("t2_held_stall", 32'(dif.in_ready), 0);
    tick();
    chk("t2_issued", 32'(dif.out_valid), 0);
    chk("t2_cnt1", 32'(dut.r_cnt[1]), 1);
    chk("t2_cnt_stall", 32'(dif.in_ready), 0);
    tick();
    dif.wb_en = 1; dif.wb_rd = 1; dif.wb_data = 5;
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("t2_wb_ready", 32'(dif.in_ready), 1);
    tick();
    dif.wb_en = 0;
`else
    #1 chk("t2_wb_ready", 32'(dif.in_ready), 0);
    tick();
    dif.wb_en = 0;
    chk("t2_wait_valid", 32'(dif.out_valid), 0);
    #1 chk("t2_after_wb_ready", 32'(dif.in_ready), 1);
    tick();
`endif
    dif.in_valid = 0;
    chk("t2_valid", 32'(dif.out_valid), 1);
    chk("t2_opa", dif.opa_mux_out, 5);
    chk("t2_opb", dif.opb_mux_out, 5);
    chk("t2_rd", 32'(dif.rd), 2);
    chk("t2_cnt1_clear", 32'(dut.r_cnt[1]), 0);
    tick();
    chk("t2_cnt2", 32'(dut.r_cnt[2]), 1);

    // Saturate x3 writers
    dif.in_valid = 1; dif.instruction = 32'h00100193; dif.pc_address = 32'h200;
    tick(); tick(); tick(); tick();
    chk("t3_cnt3", 32'(dut.r_cnt[3]), 3);
    chk("t3_valid", 32'(dif.out_valid), 0);
    #1 chk("t3_sat_stall", 32'(dif.in_ready), 0);
    tick();
    dif.wb_en = 1; dif.wb_rd = 3; dif.wb_data = 32'h33;
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("t3_wb_ready", 32'(dif.in_ready), 1);
    tick();
    dif.wb_en = 0;
`else
    #1 chk("t3_wb_ready", 32'(dif.in_ready), 0);
    tick();
    dif.wb_en = 0;
    #1 chk("t3_after_wb_ready", 32'(dif.in_ready), 1);
    tick();
`endif
    dif.in_valid = 0;
    chk("t3_valid4", 32'(dif.out_valid), 1);
    chk("t3_cnt3_dec", 32'(dut.r_cnt[3]), 2);
    tick();
    chk("t3_cnt3_full", 32'(dut.r_cnt[3]), 3);

    // wb to x0 is dropped; ADD x8,x0,x0 must still see zeros
    dif.wb_en = 1; dif.wb_rd = 0; dif.wb_data = 32'hDEAD;
    dif.in_valid = 1; dif.instruction = 32'h00000433; dif.pc_address = 32'h300;
    tick();
    dif.wb_en = 0; dif.in_valid = 0;
    chk("x0_opa", dif.opa_mux_out, 0);
    chk("x0_opb", dif.opb_mux_out, 0);
    chk("x0_cnt3", 32'(dut.r_cnt[3]), 3);

    // Branches
    dif.wb_en = 1; dif.wb_rd = 4; dif.wb_data = 7; tick();
    dif.wb_rd = 5; tick();
    dif.wb_en = 0;
    chk("zero_cnt_wb", 32'(dut.r_cnt[4]), 0);
    dif.in_valid = 1; dif.instruction = 32'h00520463; dif.pc_address = 32'h400;
    tick();
    dif.in_valid = 0;
    chk("beq_taken", 32'(dif.branch_result), 1);
    chk("beq_opa", dif.opa_mux_out, 32'h400);
    chk("beq_opb", dif.opb_mux_out, 8);
    chk("beq_rw", 32'(dif.reg_write), 0);
    dif.wb_en = 1; dif.wb_rd = 4; dif.wb_data = 32'hFFFFFFFF; tick();
    dif.wb_rd = 5; dif.wb_data = 1; tick();
    dif.wb_en = 0;
    dif.in_valid = 1; dif.instruction = 32'h00526463; tick();
    chk("bltu_not_taken", 32'(dif.branch_result), 0);
    dif.instruction = 32'h00524463; tick();
    dif.in_valid = 0;
    chk("blt_taken", 32'(dif.branch_result), 1);
    tick();

    // Flush a held entry
    dif.out_ready = 0;
    dif.in_valid = 1; dif.instruction = 32'h00900313; dif.pc_address = 32'h500;
    tick();
    dif.in_valid = 0;
    chk("t5_opb", dif.opb_mux_out, 9);
    tick();
    chk("t5_hold_rd", 32'(dif.rd), 6);
    dif.flush = 1;
    #1 chk("t5_flush_ready", 32'(dif.in_ready), 0);
    tick();
    dif.flush = 0;
    chk("t5_flushed", 32'(dif.out_valid), 0);
    chk("t5_cnt6", 32'(dut.r_cnt[6]), 0);
    dif.in_valid = 1; tick();
    dif.in_valid = 0; dif.out_ready = 1; dif.flush = 1;
    tick();
    dif.flush = 0;
    chk("t5_flush_rdy_valid", 32'(dif.out_valid), 0);
    chk("t5_flush_rdy_cnt6", 32'(dut.r_cnt[6]), 0);

    // Reset while an entry is held and an x3 writer is stalled
    dif.out_ready = 0;
    dif.in_valid = 1; dif.instruction = 32'h00100493; tick();
    dif.instruction = 32'h00100193;
    #1 chk("rst_mid_stall", 32'(dif.in_ready), 0);
    rst = 1;
    #1;
    chk("rst_mid_valid", 32'(dif.out_valid), 0);
    chk("rst_mid_cnt3", 32'(dut.r_cnt[3]), 0);
    tick();
    rst = 0; dif.out_ready = 1;
    #1 chk("post_rst_ready", 32'(dif.in_ready), 1);
    tick();
    dif.in_valid = 0;
    chk("post_rst_valid", 32'(dif.out_valid), 1);
    chk("post_rst_rd", 32'(dif.rd), 3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
